// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scheduler.
package hazard_pkg;

    localparam int unsigned REG_W    = 3;
    localparam int unsigned SB_DEPTH = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Compares one source specifier against every scoreboard slot.
module sb_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0]            src,
    input  sb_entry_t [SB_DEPTH-1:0]    slots,
    output logic                        hit_c
);

    // Hit when any valid in-flight destination equals the source.
    always_comb begin
        hit_c = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (slots[i].valid && (slots[i].dest == src)) begin
                hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW hazard stall, branch flush and HALT drain control beside decode.
// REG_W and SB_DEPTH mirror hazard_pkg and must be left at their defaults.
module hazard_scheduler #(
    parameter int unsigned REG_W    = hazard_pkg::REG_W,
    parameter int unsigned SB_DEPTH = hazard_pkg::SB_DEPTH,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] readReg1,
    input  logic [REG_W-1:0] readReg2,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             RegWrite,
    input  logic [REG_W-1:0] writeReg,
    input  logic             createdump,
    input  logic             br_taken,
    output logic             fetch_enable,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    import hazard_pkg::*;

    state_t                   state;
    state_t                   state_nxt;
    sb_entry_t [SB_DEPTH-1:0] sb;
    logic                     rs_hit_c;
    logic                     rt_hit_c;
    logic                     hazard_c;
    logic                     issue_c;

    sb_match u_rs_match (
        .src   (readReg1),
        .slots (sb),
        .hit_c (rs_hit_c)
    );

    sb_match u_rt_match (
        .src   (readReg2),
        .slots (sb),
        .hit_c (rt_hit_c)
    );

    assign halted   = (state == ST_HALT);
    assign hazard_c = dec_valid & ~halted & ((use_rs & rs_hit_c) | (use_rt & rt_hit_c));
    assign issue_c  = ~hazard_c & ~br_taken & ~halted;

    // Next state and Mealy pipeline controls; priority rst > branch > halt > hazard.
    always_comb begin
        state_nxt    = state;
        fetch_enable = 1'b1;
        bubble       = 1'b0;
        flush        = 1'b0;

        if ((state == ST_RUN) && issue_c && dec_valid && createdump) begin
            state_nxt = ST_HALT;
        end

        if (!rst) begin
            state_nxt = ST_RUN;
        end else if (br_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (halted || hazard_c) begin
            fetch_enable = 1'b0;
            bubble       = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Scoreboard shifts every cycle: EX takes the issuing entry, MEM takes EX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            for (int unsigned i = 1; i < SB_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
            sb[0] <= sb_entry_t'{valid: dec_valid & RegWrite & issue_c, dest: writeReg};
        end
    end

    // Saturating hazard-stall counter; branch-discarded hazards are not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard_c && !br_taken && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with a per-cycle issue-history model.
module tb_hazard_scheduler;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             dec_valid = 1'b0;
    logic [2:0]       readReg1 = '0;
    logic [2:0]       readReg2 = '0;
    logic             use_rs = 1'b0;
    logic             use_rt = 1'b0;
    logic             RegWrite = 1'b0;
    logic [2:0]       writeReg = '0;
    logic             createdump = 1'b0;
    logic             br_taken = 1'b0;
    logic             fetch_enable;
    logic             bubble;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scheduler #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .use_rs       (use_rs),
        .use_rt       (use_rt),
        .RegWrite     (RegWrite),
        .writeReg     (writeReg),
        .createdump   (createdump),
        .br_taken     (br_taken),
        .fetch_enable (fetch_enable),
        .bubble       (bubble),
        .flush        (flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: remembers the cycle each register was last written by an issued
    // instruction; a reader must wait until that write is 3+ cycles old.
    int  last_iss[8];
    int  cyc = 0;
    bit  m_halted = 1'b0;
    int  m_cnt = 0;
    bit  model_ok = 1'b0;

    function automatic bit in_flight(input logic [2:0] r);
        return ((cyc - last_iss[r]) >= 1) && ((cyc - last_iss[r]) <= 2);
    endfunction

    always @(negedge clk) begin
        bit hz;
        bit iss;
        hz = dec_valid && !m_halted &&
             ((use_rs && in_flight(readReg1)) || (use_rt && in_flight(readReg2)));
        if (model_ok) begin
            chk("m_halted", int'(halted), int'(m_halted));
            chk("m_stall_cnt", int'(stall_cnt), m_cnt);
            if (!rst) begin
                chk("m_fe", int'(fetch_enable), 1);
                chk("m_bubble", int'(bubble), 0);
                chk("m_flush", int'(flush), 0);
            end else if (br_taken) begin
                chk("m_fe", int'(fetch_enable), 1);
                chk("m_bubble", int'(bubble), 1);
                chk("m_flush", int'(flush), 1);
            end else if (m_halted || hz) begin
                chk("m_fe", int'(fetch_enable), 0);
                chk("m_bubble", int'(bubble), 1);
                chk("m_flush", int'(flush), 0);
            end else begin
                chk("m_fe", int'(fetch_enable), 1);
                chk("m_bubble", int'(bubble), 0);
                chk("m_flush", int'(flush), 0);
            end
        end
        if (!rst) begin
            for (int r = 0; r < 8; r++) last_iss[r] = -100;
            m_halted = 1'b0;
            m_cnt    = 0;
            model_ok = 1'b1;
        end else begin
            iss = !hz && !br_taken && !m_halted;
            if (iss && dec_valid && RegWrite) last_iss[writeReg] = cyc;
            if (hz && !br_taken && m_cnt < CNT_MAX) m_cnt++;
            if (iss && dec_valid && createdump) m_halted = 1'b1;
        end
        cyc++;
    end

    task automatic set_in(input logic v, input int r1, input int r2, input logic ur,
                          input logic ut, input logic rw, input int wr,
                          input logic cd, input logic br);
        dec_valid  = v;
        readReg1   = 3'(r1);
        readReg2   = 3'(r2);
        use_rs     = ur;
        use_rt     = ut;
        RegWrite   = rw;
        writeReg   = 3'(wr);
        createdump = cd;
        br_taken   = br;
    endtask

    task automatic idle();
        set_in(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Hold one decoded instruction until fetch_enable accepts it; counts stalls.
    task automatic run_instr(input int r1, input int r2, input logic ur, input logic ut,
                             input logic rw, input int wr, input logic cd,
                             output int stalls);
        bit done = 1'b0;
        set_in(1'b1, r1, r2, ur, ut, rw, wr, cd, 1'b0);
        stalls = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (fetch_enable) done = 1'b1;
            else stalls++;
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int s;

        // Reset values during and after reset.
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_fe", int'(fetch_enable), 1);
        chk("rst_bubble", int'(bubble), 0);
        chk("rst_flush", int'(flush), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_halted", int'(halted), 0);
        chk("post_rst_cnt", int'(stall_cnt), 0);
        @(posedge clk); #1;

        // Distance 1: ADD r1 ; ADD r3,r1,r2 -> 2 stalls.
        run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, s);
        run_instr(1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0, s);
        chk("dist1_stalls", s, 2);
        @(negedge clk);
        chk("dist1_cnt", int'(stall_cnt), 2);
        @(posedge clk); #1;

        // Distance 2: one independent NOP in between -> 1 stall.
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, s);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, s);
        run_instr(2, 1, 1'b1, 1'b1, 1'b1, 4, 1'b0, s);
        chk("dist2_stalls", s, 1);

        // Distance 3: two independent instructions in between -> 0 stalls.
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, s);
        run_instr(4, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, s);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, s);
        run_instr(1, 0, 1'b1, 1'b0, 1'b1, 7, 1'b0, s);
        chk("dist3_stalls", s, 0);

        // Store does not create a hazard; self-dependency is not a hazard.
        do_reset();
        run_instr(2, 0, 1'b1, 1'b0, 1'b0, 1, 1'b0, s);
        run_instr(1, 0, 1'b1, 1'b0, 1'b1, 3, 1'b0, s);
        chk("store_stalls", s, 0);
        run_instr(2, 2, 1'b1, 1'b1, 1'b1, 2, 1'b0, s);
        chk("self_stalls", s, 0);

        // Branch while ID holds a hazarding reader.
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, s);
        set_in(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b1);
        @(negedge clk);
        chk("br_flush", int'(flush), 1);
        chk("br_bubble", int'(bubble), 1);
        chk("br_fe", int'(fetch_enable), 1);
        @(posedge clk); #1;
        run_instr(5, 0, 1'b1, 1'b0, 1'b1, 6, 1'b0, s);
        chk("br_slot0_invalid", s, 0);
        chk("br_cnt", int'(stall_cnt), 0);

        // HALT with no hazard, then reset out of HALT.
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, s);
        @(negedge clk);
        chk("halt_halted", int'(halted), 1);
        chk("halt_fe", int'(fetch_enable), 0);
        chk("halt_bubble", int'(bubble), 1);
        @(posedge clk); #1;
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("halt_hold_fe", int'(fetch_enable), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_halted", int'(halted), 0);
        chk("halt_rst_fe", int'(fetch_enable), 1);
        chk("halt_rst_bubble", int'(bubble), 0);
        @(posedge clk); #1;

        // HALT cancelled by a taken branch.
        set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("halt_br_halted", int'(halted), 0);
        @(posedge clk); #1;

        // Chain of dependent writers: 9 dependencies x 2 stalls, saturates at 15.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_instr(1, 0, 1'b1, 1'b0, 1'b1, 1, 1'b0, s);
        end
        @(negedge clk);
        chk("sat_cnt", int'(stall_cnt), 15);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
